data_memory_sized: RTL and testbench

Parametrised big-endian, byte-addressable data memory for the single-cycle/multi-cycle CPU datapath. It supports byte/halfword/word loads and stores, sign- or zero-extended loads, alignment and range fault detection, and a registered one-cycle read response with a valid flag. It sits between the ALU address result and the write-back mux, in the same datapath position as the earlier fixed 32-bit data memory.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_byte_lane.sv | 23 ++
 rtl/data_memory_sized.sv | 112 +++++++++++
 tb/tb_data_memory_sized.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the sized data memory.
package dmem_pkg;

   // Access size as presented on the Size port.
   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_BAD  = 2'd3
   } size_e;

   // Number of bytes touched by an access; 0 marks an illegal size.
   function automatic int size_bytes(size_e sz, int word_bytes);
      case (sz)
         SZ_BYTE: return 1;
         SZ_HALF: return 2;
         SZ_WORD: return word_bytes;
         default: return 0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_byte_lane.sv
// One byte-wide RAM bank: synchronous write, asynchronous read.
module dmem_byte_lane #(
   parameter int ROWS  = 32,
   parameter int ROW_W = 5
) (
   input  logic             clk,
   input  logic             we,
   input  logic [ROW_W-1:0] row,
   input  logic [7:0]       wdata,
   output logic [7:0]       rdata
);

   logic [7:0] mem [ROWS];

   // Commit the addressed byte on the rising edge when enabled.
   // NOTE: the storage array has no reset branch; clearing it would turn the RAM into flops.
   always_ff @(posedge clk) begin
      if (we) mem[row] <= wdata;
   end

   assign rdata = mem[row];

endmodule

// File: rtl/data_memory_sized.sv
// Big-endian byte-addressable data memory with sized, extended loads,
// fault detection and a registered one-cycle response.
module data_memory_sized
   import dmem_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int DEPTH_BYTES = 128,
   parameter int ADDR_W      = 32
) (
   input  logic              CLK,
   input  logic              RST_n,
   input  logic              Req,
   input  logic              WR,
   input  logic [1:0]        Size,
   input  logic              Unsigned,
   input  logic [ADDR_W-1:0] DAddr,
   input  logic [DATA_W-1:0] DataIn,
   output logic [DATA_W-1:0] DataOut,
   output logic              RValid,
   output logic              Fault
);

   // Lanes hold one byte each; lane 0 is the lowest address in a row (the MSB of a word).
   localparam int NB     = DATA_W / 8;
   localparam int LANE_W = $clog2(NB);
   localparam int ROWS   = DEPTH_BYTES / NB;
   localparam int ROW_W  = $clog2(ROWS);

   int                nbytes;
   int                offset;
   logic              fault;
   logic              access_ok;
   logic [ADDR_W:0]   end_addr;
   logic [ROW_W-1:0]  row;
   logic              lane_we    [NB];
   logic [7:0]        lane_wdata [NB];
   logic [7:0]        rd_data    [NB];
   logic [DATA_W-1:0] raw;
   logic [DATA_W-1:0] mask;
   logic              sign;
   logic [DATA_W-1:0] load_data;

   // Decode size, alignment and range; end_addr has a carry bit so high addresses never wrap.
   always_comb begin
      nbytes    = size_bytes(size_e'(Size), NB);
      end_addr  = {1'b0, DAddr} + (ADDR_W+1)'(nbytes);
      fault     = (nbytes == 0) || (nbytes > NB)
                || ((size_e'(Size) == SZ_HALF) && DAddr[0])
                || ((size_e'(Size) == SZ_WORD) && (|DAddr[LANE_W-1:0]))
                || (end_addr > (ADDR_W+1)'(DEPTH_BYTES));
      // Writes are blocked while reset is low so a store racing reset release is dropped.
      access_ok = Req && !fault && RST_n;
      offset    = int'(DAddr[LANE_W-1:0]);
      row       = DAddr[LANE_W +: ROW_W];
   end

   // Steer right-justified store data onto the addressed lanes, MSB at the lowest address.
   // NOTE: every lane output gets a default before the loop so no latch is inferred.
   always_comb begin
      for (int l = 0; l < NB; l++) begin
         lane_we[l]    = 1'b0;
         lane_wdata[l] = 8'h00;
         if ((l >= offset) && (l - offset < nbytes)) begin
            lane_we[l]    = access_ok && WR;
            lane_wdata[l] = DataIn[(nbytes - 1 - (l - offset)) * 8 +: 8];
         end
      end
   end

   for (genvar g = 0; g < NB; g++) begin : g_lane
      dmem_byte_lane #(
         .ROWS  (ROWS),
         .ROW_W (ROW_W)
      ) u_lane (
         .clk   (CLK),
         .we    (lane_we[g]),
         .row   (row),
         .wdata (lane_wdata[g]),
         .rdata (rd_data[g])
      );
   end

   // Assemble the loaded bytes big-endian and sign- or zero-extend to the full width.
   always_comb begin
      raw  = '0;
      mask = '0;
      sign = 1'b0;
      for (int k = 0; k < NB; k++) begin
         if ((k < nbytes) && (offset + k < NB)) begin
            if (k == 0) sign = rd_data[LANE_W'(offset)][7];
            raw  = (raw << 8) | DATA_W'(rd_data[LANE_W'(offset + k)]);
            mask = (mask << 8) | DATA_W'(8'hFF);
         end
      end
      load_data = (!Unsigned && sign) ? (raw | ~mask) : raw;
   end

   // Response registers: load data with RValid, or Fault, for the request sampled at this edge.
   // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         DataOut <= '0;
         RValid  <= 1'b0;
         Fault   <= 1'b0;
      end else begin
         RValid <= Req && !WR && !fault;
         Fault  <= Req && fault;
         if (Req && !WR && !fault) DataOut <= load_data;
      end
   end

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized: sized stores/loads, extension, faults, reset.
module tb_data_memory_sized;
   import dmem_pkg::*;

   logic        CLK = 1'b0;
   logic        RST_n;
   logic        Req;
   logic        WR;
   logic [1:0]  Size;
   logic        Unsigned;
   logic [31:0] DAddr;
   logic [31:0] DataIn;
   logic [31:0] DataOut;
   logic        RValid;
   logic        Fault;

   int checks = 0;
   int errors = 0;

   data_memory_sized #(
      .DATA_W      (32),
      .DEPTH_BYTES (128),
      .ADDR_W      (32)
   ) dut (
      .CLK      (CLK),
      .RST_n    (RST_n),
      .Req      (Req),
      .WR       (WR),
      .Size     (Size),
      .Unsigned (Unsigned),
      .DAddr    (DAddr),
      .DataIn   (DataIn),
      .DataOut  (DataOut),
      .RValid   (RValid),
      .Fault    (Fault)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one request for one edge, then leave outputs settled 1 time unit later.
   task automatic access(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] data);
      Req      = 1'b1;
      WR       = wr;
      Size     = sz;
      Unsigned = uns;
      DAddr    = addr;
      DataIn   = data;
      @(posedge CLK);
      #1;
      Req = 1'b0;
   endtask

   task automatic store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] data);
      access(1'b1, sz, 1'b0, addr, data);
   endtask

   task automatic load(input logic [1:0] sz, input logic uns, input logic [31:0] addr);
      access(1'b0, sz, uns, addr, 32'h0);
   endtask

   // Load and check data plus handshake flags in one step.
   task automatic load_check(input string tag, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] exp);
      load(sz, uns, addr);
      check({tag, "_data"}, DataOut, exp);
      check({tag, "_rvalid"}, {31'b0, RValid}, 32'd1);
      check({tag, "_fault"}, {31'b0, Fault}, 32'd0);
   endtask

   task automatic fault_check(input string tag, input logic [31:0] hold);
      check({tag, "_fault"}, {31'b0, Fault}, 32'd1);
      check({tag, "_rvalid"}, {31'b0, RValid}, 32'd0);
      check({tag, "_hold"}, DataOut, hold);
   endtask

   initial begin
      RST_n = 1'b0; Req = 1'b0; WR = 1'b0; Size = SZ_BYTE;
      Unsigned = 1'b0; DAddr = '0; DataIn = '0;
      #2;
      check("rst_data", DataOut, 32'h0);
      check("rst_flags", {30'b0, RValid, Fault}, 32'd0);
      #10 RST_n = 1'b1;
      @(posedge CLK); #1;

      // Word store/load round trip.
      store(SZ_WORD, 32'd0, 32'h1122_3344);
      check("st_word_flags", {30'b0, RValid, Fault}, 32'd0);
      load_check("ld_word0", SZ_WORD, 1'b0, 32'd0, 32'h1122_3344);

      // Byte overwrite inside a word, then signed and unsigned byte loads.
      store(SZ_BYTE, 32'd2, 32'h0000_00A5);
      load_check("ld_word_after_byte", SZ_WORD, 1'b0, 32'd0, 32'h1122_A544);
      load_check("ld_byte_s", SZ_BYTE, 1'b0, 32'd2, 32'hFFFF_FFA5);
      load_check("ld_byte_u", SZ_BYTE, 1'b1, 32'd2, 32'h0000_00A5);
      load_check("ld_byte_pos_s", SZ_BYTE, 1'b0, 32'd1, 32'h0000_0022);

      // Half store/load with both extensions.
      store(SZ_HALF, 32'd4, 32'h0000_8001);
      load_check("ld_half_s", SZ_HALF, 1'b0, 32'd4, 32'hFFFF_8001);
      load_check("ld_half_u", SZ_HALF, 1'b1, 32'd4, 32'h0000_8001);
      load_check("ld_byte5", SZ_BYTE, 1'b1, 32'd5, 32'h0000_0001);

      // Misaligned word load: fault, DataOut holds last load.
      load(SZ_WORD, 1'b0, 32'd1);
      fault_check("ld_word_misal", 32'h0000_0001);
      load(SZ_HALF, 1'b0, 32'd3);
      fault_check("ld_half_misal", 32'h0000_0001);

      // Top-of-memory half store is legal; word store there faults and leaves it alone.
      store(SZ_HALF, 32'd126, 32'h0000_BEEF);
      check("st_half126_flags", {30'b0, RValid, Fault}, 32'd0);
      store(SZ_WORD, 32'd126, 32'h1234_5678);
      fault_check("st_word126", 32'h0000_0001);
      load_check("ld_half126", SZ_HALF, 1'b1, 32'd126, 32'h0000_BEEF);
      load_check("ld_byte127", SZ_BYTE, 1'b1, 32'd127, 32'h0000_00EF);

      // Out-of-range and illegal-size requests.
      store(SZ_BYTE, 32'h0000_0080, 32'h0000_0055);
      fault_check("st_byte_0x80", 32'h0000_00EF);
      load(SZ_BYTE, 1'b1, 32'h8000_0000);
      fault_check("ld_byte_hi", 32'h0000_00EF);
      store(SZ_BAD, 32'd0, 32'hFFFF_FFFF);
      fault_check("st_size3", 32'h0000_00EF);
      load(SZ_BAD, 1'b0, 32'd0);
      fault_check("ld_size3", 32'h0000_00EF);
      load_check("ld_word0_intact", SZ_WORD, 1'b0, 32'd0, 32'h1122_A544);

      // Idle cycle: no response, data held.
      @(posedge CLK); #1;
      check("idle_flags", {30'b0, RValid, Fault}, 32'd0);
      check("idle_hold", DataOut, 32'h1122_A544);

      // Back-to-back store then load of the same byte.
      Req = 1'b1; WR = 1'b1; Size = SZ_BYTE; Unsigned = 1'b0; DAddr = 32'd3; DataIn = 32'h77;
      @(posedge CLK); #1;
      WR = 1'b0; Size = SZ_WORD; DAddr = 32'd0;
      @(posedge CLK); #1;
      Req = 1'b0;
      check("raw_data", DataOut, 32'h1122_A577);
      check("raw_rvalid", {31'b0, RValid}, 32'd1);

      // Reset mid-access clears the response immediately; contents survive.
      load(SZ_HALF, 1'b0, 32'd4);
      check("pre_rst_data", DataOut, 32'hFFFF_8001);
      #2 RST_n = 1'b0;
      #1;
      check("mid_rst_data", DataOut, 32'h0);
      check("mid_rst_rvalid", {31'b0, RValid}, 32'd0);
      #3 RST_n = 1'b1;
      @(posedge CLK); #1;
      load_check("post_rst_word0", SZ_WORD, 1'b0, 32'd0, 32'h1122_A577);
      load_check("post_rst_half126", SZ_HALF, 1'b0, 32'd126, 32'hFFFF_BEEF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Safety net so the run always terminates.
   initial begin
      #20000;
      $display("FAIL timeout observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
